digitron_scheduler: RTL

DIGITRON_SCHEDULER -- requirements
Module: digitron_scheduler

---
 rtl/digitron_scheduler.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/digitron_scheduler.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// digitron_scheduler
// Shares one 4-digit multiplexed hex display between three requesters.
// In IDLE the display is blank. On a request the round-robin winner is
// granted. Its 16-bit word is snapshotted and scanned out digit by digit.
// It keeps the display for HOLD_FRAMES frame boundaries. At the end of
// the hold the requests are re-arbitrated. If nobody asks, the block
// returns to IDLE.
//
// Ports
//   Digi_Sel_clk    in   system clock
//   Digi_Sel_reset  in   asynchronous active-high reset
//   Sched_req[2:0]  in   display requests, bit i = requester i
//   Sched_data0..2  in   16-bit hex word per requester ([3:0] = rightmost)
//   Sched_gnt[2:0]  out  one-hot display owner, 0 when idle
//   Sched_busy      out  high while a requester owns the display
//   Digi_Sel_xo     out  current digit index
//   Sched_AN[3:0]   out  active-low digit enables
//   Sched_code[3:0] out  nibble to decode for the current digit
// ---------------------------------------------------------------------------
module digitron_scheduler #(
  parameter int SCAN_BITS   = 18,
  parameter int HOLD_FRAMES = 4
) (
  input  logic        Digi_Sel_clk,
  input  logic        Digi_Sel_reset,
  input  logic [2:0]  Sched_req,
  input  logic [15:0] Sched_data0,
  input  logic [15:0] Sched_data1,
  input  logic [15:0] Sched_data2,
  output logic [2:0]  Sched_gnt,
  output logic        Sched_busy,
  output logic [1:0]  Digi_Sel_xo,
  output logic [3:0]  Sched_AN,
  output logic [3:0]  Sched_code
);

  localparam int             CW     = SCAN_BITS + 2;
  localparam logic [3:0]     HOLD_L = 4'(HOLD_FRAMES);
  localparam logic [CW-1:0]  ONE_C  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] scan_q;
  logic [2:0]    gnt_q, gnt_d;
  logic [1:0]    last_q, last_d;
  logic [15:0]   data_q, data_d;
  logic [3:0]    frames_q, frames_d;

  logic [1:0]    win_s;
  logic [15:0]   win_data_s;
  logic          frame_end_s;
  logic [3:0]    frames_inc_s;
  logic          hold_done_s;

  // Round robin: search starts one past the last owner and wraps modulo 3.
  // The result is only used when req is non-zero.
  function automatic logic [1:0] rr_pick(input logic [1:0] last,
                                         input logic [2:0] req);
    logic [1:0] a, b, c;
    case (last)
      2'd0:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
      2'd1:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
      default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
    endcase
    if (req[a]) begin
      rr_pick = a;
    end else if (req[b]) begin
      rr_pick = b;
    end else begin
      rr_pick = c;
    end
  endfunction

  assign frame_end_s  = &scan_q;
  assign frames_inc_s = (frames_q == 4'hF) ? frames_q : (frames_q + 4'd1);
  assign hold_done_s  = frame_end_s && (frames_inc_s >= HOLD_L);
  assign win_s        = rr_pick(last_q, Sched_req);

  // Winner data select
  always_comb begin
    case (win_s)
      2'd0:    win_data_s = Sched_data0;
      2'd1:    win_data_s = Sched_data1;
      default: win_data_s = Sched_data2;
    endcase
  end

  // Free-running scan counter, runs in every state
  always_ff @(posedge Digi_Sel_clk or posedge Digi_Sel_reset) begin
    if (Digi_Sel_reset) begin
      scan_q <= '0;
    end else begin
      scan_q <= scan_q + ONE_C;
    end
  end

  // Next-state logic: grant from IDLE, count frames, re-arbitrate at end of hold
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    data_d   = data_q;
    frames_d = frames_q;
    case (state_q)
      IDLE: begin
        if (Sched_req != 3'b000) begin
          state_d  = SHOW;
          gnt_d    = 3'b001 << win_s;
          last_d   = win_s;
          data_d   = win_data_s;
          frames_d = 4'd0;
        end else begin
          gnt_d = 3'b000;
        end
      end
      SHOW: begin
        if (hold_done_s) begin
          if (Sched_req != 3'b000) begin
            // Back-to-back grant: stay in SHOW with no blank cycle
            gnt_d    = 3'b001 << win_s;
            last_d   = win_s;
            data_d   = win_data_s;
            frames_d = 4'd0;
          end else begin
            state_d  = IDLE;
            gnt_d    = 3'b000;
            frames_d = 4'd0;
          end
        end else if (frame_end_s) begin
          frames_d = frames_inc_s;
        end else begin
          frames_d = frames_q;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
      end
    endcase
  end

  // Scheduler state registers
  always_ff @(posedge Digi_Sel_clk or posedge Digi_Sel_reset) begin
    if (Digi_Sel_reset) begin
      state_q  <= IDLE;
      gnt_q    <= 3'b000;
      last_q   <= 2'd2;
      data_q   <= 16'h0000;
      frames_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      data_q   <= data_d;
      frames_q <= frames_d;
    end
  end

  assign Digi_Sel_xo = scan_q[CW-1:SCAN_BITS];
  assign Sched_gnt   = gnt_q;
  assign Sched_busy  = (state_q == SHOW);

  // Digit drive: from registered state and scan counter only
  always_comb begin
    Sched_AN   = 4'b1111;
    Sched_code = 4'h0;
    if (state_q == SHOW) begin
      Sched_AN = ~(4'b0001 << Digi_Sel_xo);
      case (Digi_Sel_xo)
        2'd0:    Sched_code = data_q[3:0];
        2'd1:    Sched_code = data_q[7:4];
        2'd2:    Sched_code = data_q[11:8];
        default: Sched_code = data_q[15:12];
      endcase
    end else begin
      Sched_AN   = 4'b1111;
      Sched_code = 4'h0;
    end
  end

endmodule
